peak_detector_multi: RTL and testbench

- Parametrised successor to the single-channel 32-bit peak detector.
- Tracks the extremum (max or min, signed or unsigned) of N_CH parallel waveform channels inside a programmable address window.
- One peak value and one peak address per channel, reported once per frame.
- Sits between the ADC stream and the AXI register/BRAM readout.
- One shared sample-address counter; one tracker instance per channel.

---
 rtl/peak_detector_pkg.sv | 19 +
 rtl/peak_detector_multi_if.sv | 29 ++
 rtl/peak_detector_multi_tracker.sv | 63 ++++++
 rtl/peak_detector_multi.sv | 100 ++++++++++
 tb/tb_peak_detector_multi.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/peak_detector_pkg.sv
// Shared constants and window decode for the multi-channel peak detector.
package peak_detector_pkg;
  localparam int DEF_WFM_WIDTH  = 8;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_N_CH       = 2;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_MIN = 1'b1;

  // low > high describes a window that wraps through address 0
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] low,
                                     input logic [31:0] high);
    logic r;
    if (low <= high) r = (addr >= low) && (addr <= high);
    else             r = (addr >= low) || (addr <= high);
    return r;
  endfunction
endpackage

// File: rtl/peak_detector_multi_if.sv
// Sample stream, window config and per-frame result bus of the peak detector.
interface peak_detector_multi_if
  import peak_detector_pkg::*;
#(
  parameter int WFM_WIDTH  = DEF_WFM_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N_CH       = DEF_N_CH
);
  logic [N_CH*DATA_WIDTH-1:0] din;
  logic                       s_axis_tvalid;
  logic [WFM_WIDTH-1:0]       address_low;
  logic [WFM_WIDTH-1:0]       address_high;
  logic [WFM_WIDTH-1:0]       address_reset;
  logic                       find_min;
  logic [N_CH*WFM_WIDTH-1:0]  address_out;
  logic [N_CH*DATA_WIDTH-1:0] peak_out;
  logic [N_CH-1:0]            empty_out;
  logic                       m_axis_tvalid;

  modport master (
    output din, s_axis_tvalid, address_low, address_high, address_reset, find_min,
    input  address_out, peak_out, empty_out, m_axis_tvalid
  );

  modport slave (
    input  din, s_axis_tvalid, address_low, address_high, address_reset, find_min,
    output address_out, peak_out, empty_out, m_axis_tvalid
  );
endinterface

// File: rtl/peak_detector_multi_tracker.sv
// One channel's running extremum. Outputs are the contents after the current
// beat is evaluated, so the top can latch them on the frame-end beat.
module peak_tracker
  import peak_detector_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int WFM_WIDTH  = DEF_WFM_WIDTH,
  parameter int SIGNED     = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] i_sample,
  input  logic [WFM_WIDTH-1:0]  i_addr,
  input  logic                  i_in_window,
  input  logic                  i_beat,
  input  logic                  i_frame_end,
  input  logic                  i_find_min,
  output logic [DATA_WIDTH-1:0] o_value,
  output logic [WFM_WIDTH-1:0]  o_address,
  output logic                  o_empty
);
  logic                  r_first;
  logic [DATA_WIDTH-1:0] r_value;
  logic [WFM_WIDTH-1:0]  r_address;
  logic                  w_gt, w_lt, w_take;

  always_comb begin
    if (SIGNED != 0) begin
      w_gt = $signed(i_sample) > $signed(r_value);
      w_lt = $signed(i_sample) < $signed(r_value);
    end else begin
      w_gt = i_sample > r_value;
      w_lt = i_sample < r_value;
    end
  end

  // strict compare: on a tie the earlier sample stays
  always_comb begin
    w_take = 1'b0;
    if (i_beat && i_in_window)
      w_take = r_first || ((i_find_min == MODE_MIN) ? w_lt : w_gt);
  end

  assign o_value   = w_take ? i_sample : r_value;
  assign o_address = w_take ? i_addr   : r_address;
  assign o_empty   = r_first && !w_take;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_first   <= 1'b1;
      r_value   <= '0;
      r_address <= '0;
    end else if (i_frame_end) begin
      r_first   <= 1'b1;
      r_value   <= '0;
      r_address <= '0;
    end else if (w_take) begin
      r_first   <= 1'b0;
      r_value   <= i_sample;
      r_address <= i_addr;
    end
  end
endmodule

// File: rtl/peak_detector_multi.sv
// N_CH-channel windowed peak detector: shared address counter and shadowed
// window config, one tracker per channel, one result strobe per frame.
module peak_detector_multi
  import peak_detector_pkg::*;
#(
  parameter int WFM_WIDTH  = DEF_WFM_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N_CH       = DEF_N_CH,
  parameter int SIGNED     = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  peak_detector_multi_if.slave bus
);
  logic [WFM_WIDTH-1:0] r_addr;
  logic [WFM_WIDTH-1:0] r_low, r_high, r_rst_addr;
  logic                 r_find_min, r_cfg_vld;
  logic [WFM_WIDTH-1:0] w_low, w_high, w_rst_addr;
  logic                 w_find_min;
  logic                 w_beat, w_in_win, w_frame_end;

  logic [N_CH-1:0][DATA_WIDTH-1:0] w_din, w_val, r_peak;
  logic [N_CH-1:0][WFM_WIDTH-1:0]  w_adr, r_paddr;
  logic [N_CH-1:0]                 w_empty, r_empty;
  logic                            r_stb;

  // Until the shadow is captured (first edge after reset) the ports are live.
  assign w_low      = r_cfg_vld ? r_low      : bus.address_low;
  assign w_high     = r_cfg_vld ? r_high     : bus.address_high;
  assign w_rst_addr = r_cfg_vld ? r_rst_addr : bus.address_reset;
  assign w_find_min = r_cfg_vld ? r_find_min : bus.find_min;

  assign w_beat      = bus.s_axis_tvalid;
  assign w_in_win    = in_window(32'(r_addr), 32'(w_low), 32'(w_high));
  assign w_frame_end = w_beat && (r_addr == w_rst_addr);
  assign w_din       = bus.din;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr     <= '0;
      r_low      <= '0;
      r_high     <= '0;
      r_rst_addr <= '0;
      r_find_min <= MODE_MAX;
      r_cfg_vld  <= 1'b0;
    end else begin
      if (!r_cfg_vld || w_frame_end) begin
        r_low      <= bus.address_low;
        r_high     <= bus.address_high;
        r_rst_addr <= bus.address_reset;
        r_find_min <= bus.find_min;
        r_cfg_vld  <= 1'b1;
      end
      if (w_beat) r_addr <= r_addr + WFM_WIDTH'(1);
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    peak_tracker #(
      .DATA_WIDTH (DATA_WIDTH),
      .WFM_WIDTH  (WFM_WIDTH),
      .SIGNED     (SIGNED)
    ) u_trk (
      .clk         (clk),
      .resetn      (resetn),
      .i_sample    (w_din[k]),
      .i_addr      (r_addr),
      .i_in_window (w_in_win),
      .i_beat      (w_beat),
      .i_frame_end (w_frame_end),
      .i_find_min  (w_find_min),
      .o_value     (w_val[k]),
      .o_address   (w_adr[k]),
      .o_empty     (w_empty[k])
    );
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stb   <= 1'b0;
      r_peak  <= '0;
      r_paddr <= '0;
      r_empty <= '0;
    end else begin
      r_stb <= w_frame_end;
      if (w_frame_end) begin
        r_empty <= w_empty;
        for (int k = 0; k < N_CH; k++) begin
          r_peak[k]  <= w_empty[k] ? '0 : w_val[k];
          r_paddr[k] <= w_empty[k] ? '0 : w_adr[k];
        end
      end
    end
  end

  assign bus.m_axis_tvalid = r_stb;
  assign bus.peak_out      = r_peak;
  assign bus.address_out   = r_paddr;
  assign bus.empty_out     = r_empty;
endmodule

// File: tb/tb_peak_detector_multi.sv
// Drives an unsigned and a signed peak detector with the same stream and checks
// both against a frame-level reference model every cycle.
module tb_peak_detector_multi;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int NC = 2;
  localparam int FL = 1 << AW;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic [NC*DW-1:0] din;
  logic             tvalid;
  logic [AW-1:0]    lo, hi, ar;
  logic             fmin;

  peak_detector_multi_if #(.WFM_WIDTH(AW), .DATA_WIDTH(DW), .N_CH(NC)) bu ();
  peak_detector_multi_if #(.WFM_WIDTH(AW), .DATA_WIDTH(DW), .N_CH(NC)) bs ();

  assign bu.din = din;  assign bu.s_axis_tvalid = tvalid;
  assign bu.address_low = lo;  assign bu.address_high = hi;
  assign bu.address_reset = ar;  assign bu.find_min = fmin;
  assign bs.din = din;  assign bs.s_axis_tvalid = tvalid;
  assign bs.address_low = lo;  assign bs.address_high = hi;
  assign bs.address_reset = ar;  assign bs.find_min = fmin;

  peak_detector_multi #(.WFM_WIDTH(AW), .DATA_WIDTH(DW), .N_CH(NC), .SIGNED(0))
    u_dut_u (.clk(clk), .resetn(resetn), .bus(bu.slave));
  peak_detector_multi #(.WFM_WIDTH(AW), .DATA_WIDTH(DW), .N_CH(NC), .SIGNED(1))
    u_dut_s (.clk(clk), .resetn(resetn), .bus(bs.slave));

  int total = 0, bad = 0, stb_cnt = 0, s_addr = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  int              m_cnt = 0;
  bit              m_cv = 1'b0;
  logic [AW-1:0]   c_lo = '0, c_hi = '0, c_ar = '0;
  logic            c_min = 1'b0;
  logic [NC*DW-1:0] fd[$];
  int              fa[$];
  logic                         e_stb = 1'b0;
  logic [1:0][NC-1:0]           e_emp = '0;   // index 0: unsigned DUT, 1: signed DUT
  logic [1:0][NC-1:0][DW-1:0]   e_pk = '0;
  logic [1:0][NC-1:0][AW-1:0]   e_ad = '0;

  function automatic bit in_win(input int a, input int l, input int h);
    if (l <= h) return (a >= l) && (a <= h);
    return (a >= l) || (a <= h);
  endfunction

  function automatic bit better(input logic [DW-1:0] x, input logic [DW-1:0] b,
                                input bit sgn, input bit mn);
    int xi, bi;
    xi = sgn ? int'($signed(x)) : int'(x);
    bi = sgn ? int'($signed(b)) : int'(b);
    return mn ? (xi < bi) : (xi > bi);
  endfunction

  task automatic close_frame();
    bit            found;
    logic [DW-1:0] bv, x;
    int            ba;
    for (int v = 0; v < 2; v++)
      for (int k = 0; k < NC; k++) begin
        found = 1'b0; bv = '0; ba = 0;
        for (int i = 0; i < fd.size(); i++) begin
          x = fd[i][k*DW +: DW];
          if (!found || better(x, bv, v == 1, c_min)) begin
            found = 1'b1; bv = x; ba = fa[i];
          end
        end
        e_emp[v][k] = !found;
        e_pk[v][k]  = bv;
        e_ad[v][k]  = AW'(ba);
      end
    fd.delete(); fa.delete();
    e_stb = 1'b1;
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_cnt = 0; m_cv = 1'b0; fd.delete(); fa.delete();
      e_stb = 1'b0; e_emp = '0; e_pk = '0; e_ad = '0;
    end else begin
      e_stb = 1'b0;
      if (!m_cv) begin c_lo = lo; c_hi = hi; c_ar = ar; c_min = fmin; m_cv = 1'b1; end
      if (tvalid) begin
        if (in_win(m_cnt, int'(c_lo), int'(c_hi))) begin fd.push_back(din); fa.push_back(m_cnt); end
        if (m_cnt == int'(c_ar)) begin
          close_frame();
          c_lo = lo; c_hi = hi; c_ar = ar; c_min = fmin;
        end
        m_cnt = (m_cnt + 1) % FL;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("stb_u",   64'(bu.m_axis_tvalid), 64'(e_stb));
      chk("stb_s",   64'(bs.m_axis_tvalid), 64'(e_stb));
      chk("empty_u", 64'(bu.empty_out),     64'(e_emp[0]));
      chk("empty_s", 64'(bs.empty_out),     64'(e_emp[1]));
      chk("peak_u",  64'(bu.peak_out),      64'(e_pk[0]));
      chk("peak_s",  64'(bs.peak_out),      64'(e_pk[1]));
      chk("addr_u",  64'(bu.address_out),   64'(e_ad[0]));
      chk("addr_s",  64'(bs.address_out),   64'(e_ad[1]));
      if (bu.m_axis_tvalid) stb_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [DW-1:0] rs();
    logic [DW-1:0] v;
    v = DW'($urandom_range(0, 7));
    if ($urandom_range(0, 1) == 1) v = v | 16'hFFF8;
    return v;
  endfunction

  task automatic beat(input logic [DW-1:0] a, input logic [DW-1:0] b);
    @(negedge clk);
    tvalid = 1'b1; din = {b, a};
    s_addr = (s_addr + 1) % FL;
  endtask

  task automatic idle();
    @(negedge clk);
    tvalid = 1'b0; din = {rs(), rs()};
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 resetn = 1'b0; tvalid = 1'b0; chk_on = 1'b1;
    repeat (2) @(negedge clk);
    #2 resetn = 1'b1; s_addr = 0;
  endtask

  task automatic expect_stb(input string nm);
    idle();
    chk(nm, 64'({bu.m_axis_tvalid, bs.m_axis_tvalid}), 64'(2'b11));
  endtask

  initial begin
    int n0;
    resetn = 1'b1; tvalid = 1'b0; din = '0;
    lo = 8'd0; hi = 8'd255; ar = 8'd255; fmin = 1'b0;
    do_reset();
    chk("rst_peak", 64'(bu.peak_out), 64'(0));
    chk("rst_stb",  64'(bs.m_axis_tvalid), 64'(0));

    // staircase, continuous beats
    n0 = stb_cnt;
    for (int i = 0; i < FL; i++) beat(DW'(i / 64), DW'(255 - i));
    expect_stb("stair_stb");
    chk("stair_peak_u", 64'(bu.peak_out), 64'({16'd255, 16'd3}));
    chk("stair_addr_u", 64'(bu.address_out), 64'({8'd0, 8'd192}));
    chk("stair_empty",  64'(bu.empty_out), 64'(2'b00));
    chk("stair_peak_s", 64'(bs.peak_out), 64'({16'd255, 16'd3}));
    idle();
    chk("stair_cnt", 64'(stb_cnt - n0), 64'(1));

    // same frame with tvalid every other cycle
    n0 = stb_cnt;
    for (int i = 0; i < FL; i++) begin
      beat(DW'(i / 64), DW'(255 - i));
      if (i != FL - 1) idle();
    end
    expect_stb("gap_stb");
    chk("gap_peak_u", 64'(bu.peak_out), 64'({16'd255, 16'd3}));
    chk("gap_addr_u", 64'(bu.address_out), 64'({8'd0, 8'd192}));
    idle();
    chk("gap_cnt", 64'(stb_cnt - n0), 64'(1));

    // minimum, tie between addrs 10 and 20
    fmin = 1'b1;
    do_reset();
    for (int i = 0; i < FL; i++) beat((i == 10 || i == 20) ? 16'hFFFB : 16'h0000, rs());
    expect_stb("min_stb");
    chk("min_peak_s", 64'(bs.peak_out[DW-1:0]), 64'(16'hFFFB));
    chk("min_addr_s", 64'(bs.address_out[AW-1:0]), 64'(10));
    chk("min_peak_u", 64'(bu.peak_out[DW-1:0]), 64'(0));
    chk("min_addr_u", 64'(bu.address_out[AW-1:0]), 64'(0));

    // config change mid-frame only lands at the next boundary
    fmin = 1'b0; lo = 8'd0; hi = 8'd255; ar = 8'd255;
    do_reset();
    for (int i = 0; i < FL; i++) begin
      if (i == 50) hi = 8'd10;
      beat(DW'(i), rs());
    end
    expect_stb("cfg1_stb");
    chk("cfg1_peak", 64'(bu.peak_out[DW-1:0]), 64'(255));
    chk("cfg1_addr", 64'(bu.address_out[AW-1:0]), 64'(255));
    for (int i = 0; i < FL; i++) beat(DW'(i), rs());
    expect_stb("cfg2_stb");
    chk("cfg2_peak", 64'(bs.peak_out[DW-1:0]), 64'(10));
    chk("cfg2_addr", 64'(bs.address_out[AW-1:0]), 64'(10));

    // wrapping window; 0xFFFF at addr 128 lies outside
    lo = 8'd250; hi = 8'd5; ar = 8'd100;
    do_reset();
    for (int i = 0; i <= 100; i++) beat(DW'(i), rs());
    expect_stb("wrap1_stb");
    chk("wrap1_peak", 64'(bu.peak_out[DW-1:0]), 64'(5));
    for (int j = 0; j < FL; j++) beat((s_addr == 128) ? 16'hFFFF : DW'(s_addr), rs());
    expect_stb("wrap2_stb");
    chk("wrap2_peak_u", 64'(bu.peak_out[DW-1:0]), 64'(255));
    chk("wrap2_addr_u", 64'(bu.address_out[AW-1:0]), 64'(255));
    chk("wrap2_peak_s", 64'(bs.peak_out[DW-1:0]), 64'(255));

    // reset mid-frame at addr 50: partial frame dropped, counter restarts
    while (s_addr != 50) beat(DW'(s_addr), rs());
    do_reset();
    chk("mrst_peak", 64'({bu.peak_out, bs.peak_out}), 64'(0));
    chk("mrst_addr", 64'({bu.address_out, bs.address_out}), 64'(0));
    chk("mrst_stb",  64'(bu.m_axis_tvalid), 64'(0));
    for (int i = 0; i <= 100; i++) beat(DW'(i), rs());
    expect_stb("mrst_restart_stb");
    chk("mrst_restart_peak", 64'(bu.address_out[AW-1:0]), 64'(5));

    // window never visited in the first frame
    lo = 8'd200; hi = 8'd210; ar = 8'd100;
    do_reset();
    for (int i = 0; i <= 100; i++) beat(rs(), rs());
    expect_stb("empty_stb");
    chk("empty_flags", 64'({bu.empty_out, bs.empty_out}), 64'(4'b1111));
    chk("empty_peak",  64'({bu.peak_out, bs.peak_out}), 64'(0));

    // randomized config, data, gaps and mid-frame port changes
    for (int it = 0; it < 6; it++) begin
      lo = AW'($urandom); hi = AW'($urandom); ar = AW'($urandom); fmin = 1'($urandom);
      do_reset();
      for (int c = 0; c < 700; c++) begin
        if ($urandom_range(0, 99) == 0) begin
          lo = AW'($urandom); hi = AW'($urandom); ar = AW'($urandom); fmin = 1'($urandom);
        end
        if ($urandom_range(0, 3) != 0) beat(rs(), rs());
        else idle();
      end
    end

    idle(); idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
